// File: rtl/drone_cmd_pkg.sv
// Shared command codes, state encoding and setpoint width for the flight-command sequencer.
package drone_cmd_pkg;

    localparam int SP_W = 16;

    localparam logic [7:0] CMD_DISARM  = 8'h00;
    localparam logic [7:0] CMD_TAKEOFF = 8'h01;
    localparam logic [7:0] CMD_LAND    = 8'h02;
    localparam logic [7:0] CMD_FWD     = 8'h03;
    localparam logic [7:0] CMD_BACK    = 8'h04;
    localparam logic [7:0] CMD_LEFT    = 8'h05;
    localparam logic [7:0] CMD_RIGHT   = 8'h06;
    localparam logic [7:0] CMD_HOVER   = 8'h07;
    localparam logic [7:0] CMD_ESTOP   = 8'hFF;

    typedef enum logic [2:0] {
        S_DISARMED = 3'd0,
        S_TAKEOFF  = 3'd1,
        S_HOVER    = 3'd2,
        S_MANEUVER = 3'd3,
        S_LANDING  = 3'd4,
        S_ESTOP    = 3'd5
    } state_t;

    // Motors are enabled in every state between takeoff and touchdown.
    function automatic logic is_powered(input state_t s);
        return (s == S_TAKEOFF) || (s == S_HOVER) || (s == S_MANEUVER) || (s == S_LANDING);
    endfunction

endpackage

// File: rtl/drone_tick_div.sv
// Prescaler: counts enabled cycles and emits a one-cycle tick every DIV of them.
module drone_tick_div #(
    parameter int DIV = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic i_en,
    input  logic i_clr,
    output logic o_tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] r_cnt;

    // Clear has priority so a restart lands on count 0 at the same edge.
    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= (r_cnt == LAST) ? '0 : r_cnt + W'(1);
        end
    end

    assign o_tick = i_en && (r_cnt == LAST);

endmodule

// File: rtl/drone_cmd_sequencer.sv
// Flight-command sequencer: decodes UART command bytes, runs the flight FSM,
// ramps throttle, strobes setpoints to the PID stage and lands on link loss.
module drone_cmd_sequencer
    import drone_cmd_pkg::*;
#(
    parameter logic [SP_W-1:0]        HOVER_THR    = 16'd600,
    parameter logic [SP_W-1:0]        RAMP_STEP    = 16'd4,
    parameter int                     RAMP_DIV     = 50000,
    parameter logic signed [SP_W-1:0] TILT_SP      = 16'sd100,
    parameter int                     PID_TICK_DIV = 50000,
    parameter int                     TIMEOUT_CYC  = 25000000
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rx_valid,
    input  logic [7:0]             rx_data,
    output logic [SP_W-1:0]        throttle_sp,
    output logic signed [SP_W-1:0] pitch_sp,
    output logic signed [SP_W-1:0] roll_sp,
    output logic                   armed,
    output logic                   sp_valid,
    output logic [2:0]             state,
    output logic                   failsafe,
    output logic                   cmd_err
);

    localparam int TO_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

    state_t                 r_state;
    logic [SP_W-1:0]        r_thr;
    logic signed [SP_W-1:0] r_pitch, r_roll;
    logic                   r_armed, r_sp_valid, r_fs, r_cmd_err;
    logic [TO_W-1:0]        r_to_cnt;

    state_t                 w_nxt_state;
    logic [SP_W-1:0]        w_nxt_thr;
    logic signed [SP_W-1:0] w_nxt_pitch, w_nxt_roll;
    logic                   w_nxt_fs, w_err;
    logic                   w_ramp_tick, w_pid_tick, w_airborne, w_expire;
    logic [SP_W:0]          w_thr_up, w_thr_dn;

    assign w_airborne = (r_state == S_TAKEOFF) || (r_state == S_HOVER) || (r_state == S_MANEUVER);
    assign w_expire   = w_airborne && !rx_valid && (r_to_cnt == TO_LAST);
    assign w_thr_up   = {1'b0, r_thr} + {1'b0, RAMP_STEP};
    assign w_thr_dn   = {1'b0, r_thr} - {1'b0, RAMP_STEP};

    drone_tick_div #(.DIV(RAMP_DIV)) u_ramp_div (
        .clk    (clk),
        .rst    (rst),
        .i_en   ((r_state == S_TAKEOFF) || (r_state == S_LANDING)),
        .i_clr  (w_nxt_state != r_state),
        .o_tick (w_ramp_tick)
    );

    drone_tick_div #(.DIV(PID_TICK_DIV)) u_pid_div (
        .clk    (clk),
        .rst    (rst),
        .i_en   (r_armed),
        .i_clr  (!r_armed),
        .o_tick (w_pid_tick)
    );

    // Commands are resolved first; ramp ticks and link timeout only act when
    // the command left the state unchanged.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_thr   = r_thr;
        w_nxt_pitch = r_pitch;
        w_nxt_roll  = r_roll;
        w_nxt_fs    = r_fs;
        w_err       = 1'b0;
        if (rx_valid) begin
            if (rx_data == CMD_ESTOP) begin
                w_nxt_state = S_ESTOP;
                w_nxt_thr   = '0;
                w_nxt_pitch = '0;
                w_nxt_roll  = '0;
            end else begin
                case (r_state)
                    S_DISARMED: begin
                        if (rx_data == CMD_TAKEOFF) begin
                            w_nxt_state = S_TAKEOFF;
                            w_nxt_thr   = '0;
                            w_nxt_fs    = 1'b0;
                        end else if (rx_data != CMD_DISARM) begin
                            w_err = 1'b1;
                        end
                    end
                    S_TAKEOFF: begin
                        if (rx_data == CMD_LAND || rx_data == CMD_DISARM) begin
                            w_nxt_state = S_LANDING;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    S_HOVER, S_MANEUVER: begin
                        case (rx_data)
                            CMD_DISARM, CMD_LAND: begin
                                w_nxt_state = S_LANDING;
                                w_nxt_pitch = '0;
                                w_nxt_roll  = '0;
                            end
                            CMD_FWD:   begin w_nxt_state = S_MANEUVER; w_nxt_pitch = TILT_SP;  w_nxt_roll = '0;       end
                            CMD_BACK:  begin w_nxt_state = S_MANEUVER; w_nxt_pitch = -TILT_SP; w_nxt_roll = '0;       end
                            CMD_LEFT:  begin w_nxt_state = S_MANEUVER; w_nxt_pitch = '0;       w_nxt_roll = -TILT_SP; end
                            CMD_RIGHT: begin w_nxt_state = S_MANEUVER; w_nxt_pitch = '0;       w_nxt_roll = TILT_SP;  end
                            CMD_HOVER: begin w_nxt_state = S_HOVER;    w_nxt_pitch = '0;       w_nxt_roll = '0;       end
                            default:   w_err = 1'b1;
                        endcase
                    end
                    S_ESTOP: begin
                        if (rx_data == CMD_DISARM) begin
                            w_nxt_state = S_DISARMED;
                        end else begin
                            w_err = 1'b1;
                        end
                    end
                    default: w_err = 1'b1;
                endcase
            end
        end
        if (w_nxt_state == r_state) begin
            if (w_expire) begin
                w_nxt_state = S_LANDING;
                w_nxt_fs    = 1'b1;
                w_nxt_pitch = '0;
                w_nxt_roll  = '0;
            end else if (w_ramp_tick && r_state == S_TAKEOFF) begin
                if (w_thr_up >= {1'b0, HOVER_THR}) begin
                    w_nxt_thr   = HOVER_THR;
                    w_nxt_state = S_HOVER;
                end else begin
                    w_nxt_thr = w_thr_up[SP_W-1:0];
                end
            end else if (w_ramp_tick && r_state == S_LANDING) begin
                if (w_thr_dn[SP_W] || w_thr_dn == '0) begin
                    w_nxt_thr   = '0;
                    w_nxt_state = S_DISARMED;
                end else begin
                    w_nxt_thr = w_thr_dn[SP_W-1:0];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_DISARMED;
            r_thr      <= '0;
            r_pitch    <= '0;
            r_roll     <= '0;
            r_armed    <= 1'b0;
            r_sp_valid <= 1'b0;
            r_fs       <= 1'b0;
            r_cmd_err  <= 1'b0;
        end else begin
            r_state    <= w_nxt_state;
            r_thr      <= w_nxt_thr;
            r_pitch    <= w_nxt_pitch;
            r_roll     <= w_nxt_roll;
            r_armed    <= is_powered(w_nxt_state);
            r_sp_valid <= w_pid_tick && is_powered(w_nxt_state);
            r_fs       <= w_nxt_fs;
            r_cmd_err  <= w_err;
        end
    end

    // Any received byte proves the link is alive, even an illegal one.
    always_ff @(posedge clk) begin
        if (rst || rx_valid || !w_airborne || w_expire) begin
            r_to_cnt <= '0;
        end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
        end
    end

    assign throttle_sp = r_thr;
    assign pitch_sp    = r_pitch;
    assign roll_sp     = r_roll;
    assign armed       = r_armed;
    assign sp_valid    = r_sp_valid;
    assign state       = r_state;
    assign failsafe    = r_fs;
    assign cmd_err     = r_cmd_err;

endmodule

// File: tb/tb_drone_cmd_sequencer.sv
// Directed bench for drone_cmd_sequencer with shortened ramp/PID/timeout periods.
module tb_drone_cmd_sequencer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               rx_valid = 1'b0;
    logic [7:0]         rx_data = 8'h00;
    logic [15:0]        throttle_sp;
    logic signed [15:0] pitch_sp, roll_sp;
    logic               armed, sp_valid, failsafe, cmd_err;
    logic [2:0]         state;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    drone_cmd_sequencer #(
        .HOVER_THR    (16'd20),
        .RAMP_STEP    (16'd4),
        .RAMP_DIV     (10),
        .TILT_SP      (16'sd100),
        .PID_TICK_DIV (8),
        .TIMEOUT_CYC  (500)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .throttle_sp (throttle_sp),
        .pitch_sp    (pitch_sp),
        .roll_sp     (roll_sp),
        .armed       (armed),
        .sp_valid    (sp_valid),
        .state       (state),
        .failsafe    (failsafe),
        .cmd_err     (cmd_err)
    );

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        @(posedge clk);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset state
        cyc(3);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_thr", throttle_sp, 16'd0);
        chk("rst_pitch", pitch_sp, 16'd0);
        chk("rst_roll", roll_sp, 16'd0);
        chk("rst_armed", 16'(armed), 16'd0);
        chk("rst_spv", 16'(sp_valid), 16'd0);
        chk("rst_fs", 16'(failsafe), 16'd0);
        chk("rst_err", 16'(cmd_err), 16'd0);
        rst = 1'b0;
        cyc(2);
        chk("idle_state", 16'(state), 16'd0);

        // Takeoff ramp and PID strobe
        send(8'h01);
        chk("to_state", 16'(state), 16'd1);
        chk("to_armed", 16'(armed), 16'd1);
        chk("to_thr0", throttle_sp, 16'd0);
        cyc(7);
        chk("spv_e7", 16'(sp_valid), 16'd0);
        cyc(1);
        chk("spv_e8", 16'(sp_valid), 16'd1);
        cyc(1);
        chk("spv_e9", 16'(sp_valid), 16'd0);
        chk("thr_e9", throttle_sp, 16'd0);
        cyc(1);
        chk("thr_e10", throttle_sp, 16'd4);
        cyc(6);
        chk("spv_e16", 16'(sp_valid), 16'd1);
        cyc(4);
        chk("thr_e20", throttle_sp, 16'd8);
        cyc(20);
        chk("thr_e40", throttle_sp, 16'd16);
        cyc(9);
        chk("thr_e49", throttle_sp, 16'd16);
        chk("state_e49", 16'(state), 16'd1);
        cyc(1);
        chk("thr_e50", throttle_sp, 16'd20);
        chk("state_e50", 16'(state), 16'd2);

        // Maneuvers
        send(8'h03);
        chk("fwd_state", 16'(state), 16'd3);
        chk("fwd_pitch", pitch_sp, 16'd100);
        chk("fwd_roll", roll_sp, 16'd0);
        send(8'h05);
        chk("left_roll", roll_sp, 16'hFF9C);
        chk("left_pitch", pitch_sp, 16'd0);
        send(8'h06);
        chk("right_roll", roll_sp, 16'd100);
        send(8'h04);
        chk("back_pitch", pitch_sp, 16'hFF9C);
        chk("back_roll", roll_sp, 16'd0);
        send(8'h07);
        chk("hov_state", 16'(state), 16'd2);
        chk("hov_pitch", pitch_sp, 16'd0);
        chk("hov_roll", roll_sp, 16'd0);

        // Unknown code in HOVER, then silent link
        send(8'h55);
        chk("unk_err", 16'(cmd_err), 16'd1);
        chk("unk_state", 16'(state), 16'd2);
        chk("unk_thr", throttle_sp, 16'd20);
        cyc(1);
        chk("unk_err_end", 16'(cmd_err), 16'd0);
        cyc(498);
        chk("to499_state", 16'(state), 16'd2);
        chk("to499_fs", 16'(failsafe), 16'd0);
        cyc(1);
        chk("to500_state", 16'(state), 16'd4);
        chk("to500_fs", 16'(failsafe), 16'd1);
        chk("to500_thr", throttle_sp, 16'd20);
        cyc(10);
        chk("land_thr16", throttle_sp, 16'd16);
        cyc(30);
        chk("land_thr4", throttle_sp, 16'd4);
        chk("land_armed", 16'(armed), 16'd1);
        cyc(10);
        chk("land_thr0", throttle_sp, 16'd0);
        chk("land_disarmed", 16'(state), 16'd0);
        chk("land_armed0", 16'(armed), 16'd0);
        chk("land_fs_sticky", 16'(failsafe), 16'd1);
        chk("land_spv0", 16'(sp_valid), 16'd0);

        // Illegal in DISARMED, then takeoff clears failsafe
        send(8'h03);
        chk("dis_err", 16'(cmd_err), 16'd1);
        chk("dis_state", 16'(state), 16'd0);
        chk("dis_armed", 16'(armed), 16'd0);
        send(8'h01);
        chk("re_fs", 16'(failsafe), 16'd0);
        chk("re_state", 16'(state), 16'd1);
        chk("re_err", 16'(cmd_err), 16'd0);

        // Estop during takeoff
        cyc(20);
        chk("es_thr8", throttle_sp, 16'd8);
        send(8'hFF);
        chk("es_state", 16'(state), 16'd5);
        chk("es_thr", throttle_sp, 16'd0);
        chk("es_armed", 16'(armed), 16'd0);
        send(8'h01);
        chk("es_err", 16'(cmd_err), 16'd1);
        chk("es_hold", 16'(state), 16'd5);
        send(8'h00);
        chk("es_clear", 16'(state), 16'd0);
        chk("es_clear_err", 16'(cmd_err), 16'd0);

        // LAND colliding with a ramp tick
        send(8'h01);
        cyc(9);
        send(8'h02);
        chk("col_state", 16'(state), 16'd4);
        chk("col_thr", throttle_sp, 16'd0);
        chk("col_armed", 16'(armed), 16'd1);
        send(8'h07);
        chk("ld_err", 16'(cmd_err), 16'd1);
        chk("ld_state", 16'(state), 16'd4);
        cyc(8);
        chk("col_e19", 16'(state), 16'd4);
        cyc(1);
        chk("col_e20", 16'(state), 16'd0);
        chk("col_e20_armed", 16'(armed), 16'd0);

        // Reset during a maneuver
        send(8'h01);
        cyc(50);
        chk("m_hover", 16'(state), 16'd2);
        send(8'h06);
        chk("m_roll", roll_sp, 16'd100);
        rst = 1'b1;
        cyc(1);
        chk("mr_state", 16'(state), 16'd0);
        chk("mr_thr", throttle_sp, 16'd0);
        chk("mr_roll", roll_sp, 16'd0);
        chk("mr_armed", 16'(armed), 16'd0);
        rst = 1'b0;

        // DISARM while airborne acts as LAND
        send(8'h01);
        cyc(5);
        send(8'h00);
        chk("air0_state", 16'(state), 16'd4);
        chk("air0_armed", 16'(armed), 16'd1);
        chk("air0_err", 16'(cmd_err), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/drone_cmd_sequencer.md
Name: drone_cmd_sequencer

Overview:
Flight-command sequencer between the UART byte receiver and the PID/attitude controller.
- Decodes single-byte commands arriving on the RxD path.
- Runs the arm/takeoff/hover/maneuver/land state machine.
- Ramps throttle and sets tilt setpoints.
- Issues a periodic setpoint strobe to the PID stage.
- Forces a controlled landing if the command link goes silent while airborne.

Parameters:
- HOVER_THR, 16'd600: throttle setpoint held in HOVER/MANEUVER.
- RAMP_STEP, 16'd4: throttle increment/decrement per ramp tick.
- RAMP_DIV, 50000: clk cycles per ramp tick.
- TILT_SP, 16'sd100: magnitude of pitch/roll setpoint for maneuvers.
- PID_TICK_DIV, 50000: clk cycles between sp_valid pulses.
- TIMEOUT_CYC, 25000000: silent-link cycles before failsafe landing.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: reset, synchronous, active-high.
- rx_valid, in, 1: one-cycle pulse, rx_data holds a received byte.
- rx_data, in, 8: received command byte.
- throttle_sp, out, 16: unsigned collective throttle setpoint.
- pitch_sp, out, 16: signed pitch setpoint (+ = forward).
- roll_sp, out, 16: signed roll setpoint (+ = right).
- armed, out, 1: motors enabled; PWM stage forces minimum when low.
- sp_valid, out, 1: one-cycle strobe, setpoints to be sampled by PID.
- state, out, 3: current FSM state encoding.
- failsafe, out, 1: sticky, set by link timeout.
- cmd_err, out, 1: one-cycle pulse on an unknown or illegal command.

Behaviour:
- Single clock domain. rst is synchronous active-high.
- Reset values: all outputs 0; state=DISARMED; all counters 0.
- Command codes:
  - 0x00 DISARM/CLEAR
  - 0x01 TAKEOFF
  - 0x02 LAND
  - 0x03 FWD
  - 0x04 BACK
  - 0x05 LEFT
  - 0x06 RIGHT
  - 0x07 HOVER
  - 0xFF ESTOP
- Command latency: a command is decoded on the rx_valid cycle. State and setpoint registers update at the next rising edge (1-cycle latency).
- States and transitions:
  - DISARMED:
    - 0x01 -> TAKEOFF; armed=1; throttle=0; failsafe cleared.
    - 0x00 is accepted silently.
    - Any other code -> cmd_err.
  - TAKEOFF:
    - Each ramp tick: throttle += RAMP_STEP, saturating at HOVER_THR.
    - Enters HOVER on the same edge throttle reaches HOVER_THR.
    - 0x02 -> LANDING.
    - 0x03..0x07 -> cmd_err; state unchanged.
  - HOVER:
    - pitch=roll=0.
    - 0x03/0x04 -> MANEUVER with pitch=+/-TILT_SP.
    - 0x05/0x06 -> MANEUVER with roll=-/+TILT_SP.
    - 0x02 -> LANDING.
  - MANEUVER:
    - A new direction command replaces the tilt; the other axis is zeroed.
    - 0x07 -> HOVER.
    - 0x02 -> LANDING.
  - LANDING:
    - pitch=roll=0.
    - Each ramp tick: throttle -= RAMP_STEP, saturating at 0.
    - On reaching 0 -> DISARMED; armed=0 on the same edge.
    - Only 0xFF is accepted; everything else -> cmd_err.
  - ESTOP:
    - Entered from any state on 0xFF.
    - throttle=0, pitch=roll=0, armed=0 on the next edge.
    - Leaves only on 0x00 -> DISARMED.
    - All other codes -> cmd_err.
- 0x00 while airborne (TAKEOFF/HOVER/MANEUVER) is treated as LAND. It never cuts motors mid-air.
- Undefined codes always pulse cmd_err and have no other effect.
- Ramp counter:
  - Free-runs only in TAKEOFF and LANDING; cleared to 0 on entry to either state.
  - A tick occurs when the count reaches RAMP_DIV-1.
- If a command and a ramp tick coincide, the command wins. The tick is discarded if the state changes and applied otherwise.
- PID tick:
  - Counter runs while armed.
  - sp_valid pulses for one cycle every PID_TICK_DIV cycles.
  - The first pulse comes PID_TICK_DIV cycles after armed rises.
  - sp_valid is never asserted while armed=0.
- Timeout counter:
  - Cleared on every rx_valid (any byte).
  - Counts in TAKEOFF, HOVER and MANEUVER.
  - At TIMEOUT_CYC-1: -> LANDING and failsafe=1.
  - Held at 0 in other states.
  - A rx_valid on the same cycle as expiry wins; no failsafe.
- Widths: throttle arithmetic is 17-bit internally for saturation. Tilt setpoints are two's complement 16-bit.
- rst asserted mid-flight: immediate return to reset values on that edge (armed=0).

Decomposition:
- Package drone_cmd_pkg holds:
  - command code constants (CMD_DISARM..CMD_ESTOP);
  - the 3-bit state encoding (S_DISARMED=0, S_TAKEOFF=1, S_HOVER=2, S_MANEUVER=3, S_LANDING=4, S_ESTOP=5);
  - the setpoint width constant (16).
- One sub-module, drone_tick_div: a parameterised prescaler with enable and synchronous clear, emitting a one-cycle tick. It is instantiated twice, once for the ramp and once for the PID tick.
- The timeout counter stays inline.

Test Plan:
Overrides for all scenarios: HOVER_THR=20, RAMP_STEP=4, RAMP_DIV=10, PID_TICK_DIV=8, TIMEOUT_CYC=500, TILT_SP=100.
1. Takeoff: rst, then byte 0x01. Expect armed=1 next cycle, throttle 0,4,...,20 at 10-cycle spacing, state=HOVER when throttle=20, sp_valid every 8 cycles.
2. Maneuver: in HOVER send 0x03 -> pitch_sp=+100, roll=0. Send 0x05 -> roll=-100, pitch=0. Send 0x07 -> both 0, state=HOVER.
3. Failsafe: in HOVER send nothing for 500 cycles. Expect state=LANDING and failsafe=1, throttle ramping 20->0, then DISARMED with armed=0. The next 0x01 clears failsafe.
4. Estop: during TAKEOFF (throttle=8) send 0xFF -> next edge throttle=0, armed=0, state=ESTOP. Send 0x01 -> cmd_err pulse, still ESTOP. Send 0x00 -> DISARMED.
5. Illegal/unknown: 0x03 in DISARMED and 0x55 in HOVER -> one-cycle cmd_err each, all outputs unchanged.
6. Reset mid-operation and collision: assert rst in MANEUVER -> all outputs 0 next edge. Separately, send 0x02 on a ramp-tick cycle in TAKEOFF -> LANDING, throttle not incremented.
